// File: rtl/cpu_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_controller
// Brief    : Eight-phase instruction sequencer with registered strobes for the
//            8-bit RISC CPU. Optional retired-instruction counter: PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_controller #(
  parameter int OPC_W       = 3,
  parameter int CNT_W       = 16,
  parameter int HALT_RESUME = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic [2:0]       phase,
  output logic             addr_sel,
  output logic             addr_active,
  output logic             skip,
  output logic             skip_signal,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] retired,
`endif
  output logic             halt
);

  localparam logic [OPC_W-1:0] c_op_hlt = OPC_W'(0);
  localparam logic [OPC_W-1:0] c_op_skz = OPC_W'(1);
  localparam logic [OPC_W-1:0] c_op_add = OPC_W'(2);
  localparam logic [OPC_W-1:0] c_op_and = OPC_W'(3);
  localparam logic [OPC_W-1:0] c_op_xor = OPC_W'(4);
  localparam logic [OPC_W-1:0] c_op_lda = OPC_W'(5);
  localparam logic [OPC_W-1:0] c_op_sto = OPC_W'(6);
  localparam logic [OPC_W-1:0] c_op_jmp = OPC_W'(7);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_P0   = 4'd1,
    S_P1   = 4'd2,
    S_P2   = 4'd3,
    S_P3   = 4'd4,
    S_P4   = 4'd5,
    S_P5   = 4'd6,
    S_P6   = 4'd7,
    S_P7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OPC_W-1:0] r_opc;
  logic [OPC_W-1:0] w_opc;
  logic             w_aluop;
  logic [2:0]       w_phase;
  logic             w_addr_sel, w_addr_active, w_skip, w_skip_signal;
  logic             w_mem_rd, w_mem_wr, w_ld_ir, w_inc_pc, w_ld_pc;
  logic             w_ld_ac, w_data_e, w_halt;

  // On the P3->P4 edge the opcode being latched already governs P4's strobes.
  assign w_opc   = (r_state == S_P3) ? opcode : r_opc;
  assign w_aluop = (w_opc == c_op_add) || (w_opc == c_op_and) ||
                   (w_opc == c_op_xor) || (w_opc == c_op_lda);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_P0;
      S_P0:    w_next = S_P1;
      S_P1:    w_next = S_P2;
      S_P2:    w_next = S_P3;
      S_P3:    w_next = S_P4;
      S_P4:    w_next = (r_opc == c_op_hlt) ? S_HALT : S_P5;
      S_P5:    w_next = S_P6;
      S_P6:    w_next = S_P7;
      S_P7:    w_next = S_P0;
      S_HALT:  w_next = ((HALT_RESUME != 0) && start) ? S_P0 : S_HALT;
      default: w_next = S_RST;
    endcase
  end

  // Strobes are decoded from the state being entered so they are registered.
  always_comb begin
    w_phase       = 3'd0;
    w_addr_sel    = 1'b0;
    w_addr_active = 1'b0;
    w_skip        = 1'b0;
    w_skip_signal = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_wr      = 1'b0;
    w_ld_ir       = 1'b0;
    w_inc_pc      = 1'b0;
    w_ld_pc       = 1'b0;
    w_ld_ac       = 1'b0;
    w_data_e      = 1'b0;
    w_halt        = 1'b0;
    case (w_next)
      S_P0: begin
        w_phase       = 3'd0;
        w_addr_active = 1'b1;
      end
      S_P1: begin
        w_phase       = 3'd1;
        w_addr_active = 1'b1;
        w_mem_rd      = 1'b1;
      end
      S_P2, S_P3: begin
        w_phase       = (w_next == S_P2) ? 3'd2 : 3'd3;
        w_addr_active = 1'b1;
        w_mem_rd      = 1'b1;
        w_ld_ir       = 1'b1;
      end
      S_P4: begin
        w_phase       = 3'd4;
        w_addr_active = 1'b1;
        w_addr_sel    = 1'b1;
        w_halt        = (w_opc == c_op_hlt);
        w_inc_pc      = (w_opc != c_op_hlt);
      end
      S_P5: begin
        w_phase       = 3'd5;
        w_addr_active = 1'b1;
        w_addr_sel    = 1'b1;
        w_mem_rd      = w_aluop;
      end
      S_P6: begin
        // Entered only from P5, so zero is sampled on exactly the P5->P6 edge.
        w_phase       = 3'd6;
        w_addr_active = 1'b1;
        w_addr_sel    = 1'b1;
        w_mem_rd      = w_aluop;
        w_data_e      = (w_opc == c_op_sto);
        w_ld_pc       = (w_opc == c_op_jmp);
        w_inc_pc      = (w_opc == c_op_skz) && zero;
        w_skip_signal = (w_opc == c_op_skz) && zero;
      end
      S_P7: begin
        w_phase       = 3'd7;
        w_addr_active = 1'b1;
        w_addr_sel    = 1'b1;
        w_mem_rd      = w_aluop;
        w_ld_ac       = w_aluop;
        w_mem_wr      = (w_opc == c_op_sto);
        w_data_e      = (w_opc == c_op_sto);
        w_ld_pc       = (w_opc == c_op_jmp);
        w_skip        = (w_opc == c_op_jmp);
      end
      S_HALT: begin
        w_phase = 3'd4;
        w_halt  = 1'b1;
      end
      default: begin
        w_phase = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RST;
      r_opc       <= c_op_hlt;
      phase       <= 3'd0;
      addr_sel    <= 1'b0;
      addr_active <= 1'b0;
      skip        <= 1'b0;
      skip_signal <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      ld_ir       <= 1'b0;
      inc_pc      <= 1'b0;
      ld_pc       <= 1'b0;
      ld_ac       <= 1'b0;
      data_e      <= 1'b0;
      halt        <= 1'b0;
`ifdef PERF_CNT_EN
      retired     <= '0;
`endif
    end else if (enable) begin
      r_state     <= w_next;
      r_opc       <= w_opc;
      phase       <= w_phase;
      addr_sel    <= w_addr_sel;
      addr_active <= w_addr_active;
      skip        <= w_skip;
      skip_signal <= w_skip_signal;
      mem_rd      <= w_mem_rd;
      mem_wr      <= w_mem_wr;
      ld_ir       <= w_ld_ir;
      inc_pc      <= w_inc_pc;
      ld_pc       <= w_ld_pc;
      ld_ac       <= w_ld_ac;
      data_e      <= w_data_e;
      halt        <= w_halt;
`ifdef PERF_CNT_EN
      if (r_state == S_P7) retired <= retired + 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire
